// File: rtl/dmux_route_ctrl_pkg.sv
// Shared types and constants for the dmux1x16 route controller.
// The controller's own SEL_W parameter takes precedence over the package constant.
package dmux_pkg;

    localparam int SEL_W     = 4;
    localparam int N_CHAN    = 1 << SEL_W;
    localparam int CHAN_LAST = N_CHAN - 1;

    typedef logic [SEL_W-1:0] chan_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/dmux_route_ctrl_if.sv
// Command channel of the route controller, grouped so benches and parents bind it in one go.
interface dmux_route_ctrl_if #(
    parameter int SEL_W  = 4,
    parameter int HOLD_W = 8
);

    // A command transfers on a rising edge where cmd_valid and cmd_ready are both 1.
    // While cmd_valid is high and cmd_ready is low, the payload has no effect.
    // The payload is sampled only on the transfer edge.
    logic              cmd_valid;
    logic              cmd_ready;
    logic [SEL_W-1:0]  cmd_chan;
    logic              cmd_data;
    logic [HOLD_W-1:0] cmd_hold;
    logic              cmd_scan;

    modport master (
        output cmd_valid, cmd_chan, cmd_data, cmd_hold, cmd_scan,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_chan, cmd_data, cmd_hold, cmd_scan,
        output cmd_ready
    );

endinterface

// File: rtl/dmux_route_ctrl_hold_timer.sv
// Loadable down-counter that times how long each channel is driven.
// The zero flag marks the last cycle on the current channel.
module hold_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dmux_route_ctrl.sv
// Handshaked sequencer driving dmux1x16 a/s for a programmed number of cycles per channel.
// An optional scan steps s upward to the last channel with no idle cycle between channels.
module dmux_route_ctrl #(
    parameter int SEL_W  = 4,
    parameter int HOLD_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    dmux_route_ctrl_if.slave cmd,
    input  logic             abort,
    output logic             dmux_a,
    output logic [SEL_W-1:0] dmux_s,
    output logic             busy,
    output logic             done,
    output dmux_pkg::state_t dbg_state
);

    import dmux_pkg::*;

    localparam logic [SEL_W-1:0] S_LAST = '1;

    state_t            state;
    state_t            state_nxt;
    logic              a_nxt;
    logic [SEL_W-1:0]  s_nxt;
    logic              done_nxt;
    logic              scan_q;
    logic              scan_nxt;
    logic [HOLD_W-1:0] reload_q;
    logic [HOLD_W-1:0] reload_nxt;
    logic [HOLD_W-1:0] cmd_reload;
    logic              accept;

    logic              t_clr;
    logic              t_load;
    logic [HOLD_W-1:0] t_val;
    logic              t_dec;
    logic              t_zero;

    assign cmd.cmd_ready = (state == IDLE) && !abort;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    // A hold of 0 is treated as 1, so the counter reload is max(hold,1)-1.
    assign cmd_reload    = (cmd.cmd_hold == '0) ? '0 : cmd.cmd_hold - 1'b1;
    assign dbg_state     = state;

    hold_timer #(.W(HOLD_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (t_clr),
        .load     (t_load),
        .load_val (t_val),
        .dec      (t_dec),
        .zero     (t_zero)
    );

    always_comb begin
        state_nxt  = state;
        a_nxt      = dmux_a;
        s_nxt      = dmux_s;
        done_nxt   = 1'b0;
        scan_nxt   = scan_q;
        reload_nxt = reload_q;
        t_clr      = 1'b0;
        t_load     = 1'b0;
        t_val      = reload_q;
        t_dec      = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt  = DRIVE;
                    s_nxt      = cmd.cmd_chan;
                    a_nxt      = cmd.cmd_data;
                    scan_nxt   = cmd.cmd_scan;
                    reload_nxt = cmd_reload;
                    t_load     = 1'b1;
                    t_val      = cmd_reload;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_nxt = IDLE;
                    a_nxt     = 1'b0;
                    t_clr     = 1'b1;
                end else if (!t_zero) begin
                    t_dec = 1'b1;
                end else if (scan_q && (dmux_s != S_LAST)) begin
                    s_nxt  = dmux_s + 1'b1;
                    t_load = 1'b1;
                end else begin
                    state_nxt = GAP;
                    a_nxt     = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            GAP: begin
                state_nxt = IDLE;
                a_nxt     = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                a_nxt     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dmux_a   <= 1'b0;
            dmux_s   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            scan_q   <= 1'b0;
            reload_q <= '0;
        end else begin
            state    <= state_nxt;
            dmux_a   <= a_nxt;
            dmux_s   <= s_nxt;
            busy     <= (state_nxt != IDLE);
            done     <= done_nxt;
            scan_q   <= scan_nxt;
            reload_q <= reload_nxt;
        end
    end

endmodule

// File: tb/tb_dmux_route_ctrl.sv
// Bench for dmux_route_ctrl: directed boundary cases plus random commands, with the
// dmux1x16 output y modelled from a/s and compared against a per-cycle expected queue.
module tb_dmux_route_ctrl;

    import dmux_pkg::*;

    localparam int SW = 4;
    localparam int HW = 8;
    localparam int EW = 21;

    logic          clk;
    logic          rst_n;
    logic          abort;
    logic          dmux_a;
    logic [SW-1:0] dmux_s;
    logic          busy;
    logic          done;
    state_t        dbg_state;
    logic [15:0]   y;

    logic [EW-1:0] exp_q[$];
    int            checks;
    int            errors;

    dmux_route_ctrl_if #(.SEL_W(SW), .HOLD_W(HW)) ifc ();

    dmux_route_ctrl #(.SEL_W(SW), .HOLD_W(HW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (ifc.slave),
        .abort     (abort),
        .dmux_a    (dmux_a),
        .dmux_s    (dmux_s),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // dmux1x16 behaviour: only the selected line follows a.
    always_comb begin
        y = '0;
        if (dmux_a) y[dmux_s] = 1'b1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected busy-cycle trace of one command: every channel visited for max(hold,1)
    // cycles, then one gap cycle with a=0 and done=1.
    task automatic push_model(input int chan, input int data, input int hold, input int scan);
        int h;
        int last;
        logic [15:0] ye;
        h    = (hold == 0) ? 1 : hold;
        last = scan ? 15 : chan;
        for (int c = chan; c <= last; c++) begin
            ye = '0;
            if (data != 0) ye[c] = 1'b1;
            for (int k = 0; k < h; k++) exp_q.push_back({ye, 1'b0, 4'(c)});
        end
        exp_q.push_back({16'h0000, 1'b1, 4'(last)});
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (busy) begin
            chk("ready_while_busy", 32'(ifc.cmd_ready), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_busy_cycle", 32'(busy), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("y", 32'(y), 32'(e[20:5]));
                chk("done", 32'(done), 32'(e[4]));
                chk("s", 32'(dmux_s), 32'(e[3:0]));
            end
        end else begin
            chk("idle_y", 32'(y), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int chan, input int data, input int hold, input int scan);
        bit ok;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_chan  = 4'(chan);
        ifc.cmd_data  = 1'(data);
        ifc.cmd_hold  = 8'(hold);
        ifc.cmd_scan  = 1'(scan);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ifc.cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("accept_timeout", 32'(ifc.cmd_ready), 32'd1);
        end else begin
            push_model(chan, data, hold, scan);
            @(posedge clk);
        end
        #1;
        ifc.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n         = 1'b0;
        abort         = 1'b0;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_chan  = '0;
        ifc.cmd_data  = 1'b0;
        ifc.cmd_hold  = '0;
        ifc.cmd_scan  = 1'b0;

        #12;
        chk("rst_a", 32'(dmux_a), 32'd0);
        chk("rst_s", 32'(dmux_s), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 32'(ifc.cmd_ready), 32'd1);

        // single channel, then s must persist in idle
        send(3, 1, 4, 0);
        wait_idle();
        chk("s_retained_idle", 32'(dmux_s), 32'd3);

        send(13, 1, 2, 1);
        wait_idle();
        chk("scan_stops_15", 32'(dmux_s), 32'd15);

        send(7, 0, 0, 0);
        wait_idle();
        send(15, 1, 3, 1);
        wait_idle();

        // abort in the second drive cycle
        send(9, 1, 10, 0);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        exp_q.delete();
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_a", 32'(dmux_a), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_state", 32'(dbg_state), 32'(IDLE));
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("abort_done_later", 32'(done), 32'd0);
        @(posedge clk);
        #1;

        // abort beats cmd_valid in idle
        abort         = 1'b1;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_chan  = 4'd4;
        ifc.cmd_data  = 1'b1;
        ifc.cmd_hold  = 8'd2;
        ifc.cmd_scan  = 1'b0;
        @(negedge clk);
        chk("abort_blocks_ready", 32'(ifc.cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        abort         = 1'b0;
        ifc.cmd_valid = 1'b0;
        @(negedge clk);
        chk("abort_no_accept", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // back-to-back with cmd_valid held high
        send(1, 1, 1, 0);
        send(2, 1, 1, 0);
        wait_idle();

        // reset mid-command takes effect without a clock edge
        send(5, 1, 20, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("async_rst_a", 32'(dmux_a), 32'd0);
        chk("async_rst_s", 32'(dmux_s), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_mid_reset", 32'(ifc.cmd_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int n = 0; n < 24; n++) begin
            send($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 5),
                 ($urandom_range(0, 3) == 0) ? 1 : 0);
            if ($urandom_range(0, 1) == 1) begin
                wait_idle();
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        wait_idle();
        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
